// File: rtl/dcache_pkg.sv
// Shared data-cache types: wait-buffer request bundle
// and the replay controller state encoding.
package dcache_pkg;

  localparam int ADDR_BITS  = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MICROOP    = 8;
  localparam int R_WIDTH    = 5;
  localparam int ROB_TICKET = 6;

  typedef struct packed {
    logic                  is_store;
    logic [ADDR_BITS-1:0]  addr;
    logic [DATA_WIDTH-1:0] data;
    logic [MICROOP-1:0]    microop;
    logic [R_WIDTH-1:0]    dest;
    logic [ROB_TICKET-1:0] ticket;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPLAY = 2'd2
  } replay_state_t;

endpackage

// File: rtl/wb_replay_ctrl_if.sv
// Wait-buffer search/walk bundle between the replay
// controller (master) and the wait buffer (slave).
interface wb_replay_ctrl_if
  import dcache_pkg::*;
#(
  parameter int ADDR_BITS = 32
);

  logic [ADDR_BITS-1:0] wb_search_address;
  logic                 wb_search_invalidate;
  logic                 wb_found_one;
  logic                 wb_found_multi;
  logic                 wb_in_walk_mode;
  wb_req_t              wb_entry;

  modport master (
    output wb_search_address,
    output wb_search_invalidate,
    input  wb_found_one,
    input  wb_found_multi,
    input  wb_in_walk_mode,
    input  wb_entry
  );

  modport slave (
    input  wb_search_address,
    input  wb_search_invalidate,
    output wb_found_one,
    output wb_found_multi,
    output wb_in_walk_mode,
    output wb_entry
  );

endinterface

// File: rtl/wb_replay_ctrl.sv
// Line-fill driven wait-buffer replay sequencer and
// arbiter for the single data-cache array port.
module wb_replay_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_BITS      = 32,
  parameter int BLOCK_ID_START = 5,
  parameter int DEPTH          = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int BW = ADDR_BITS - BLOCK_ID_START
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fill_valid,
  input  logic [ADDR_BITS-1:0] fill_address,
  output logic                 fill_ready,
  input  logic                 lsu_valid,
  input  wb_req_t              lsu_req,
  output logic                 lsu_ready,
  wb_replay_ctrl_if.master     wb,
  output logic                 port_valid,
  output logic                 port_is_replay,
  output wb_req_t              port_req,
  output logic [CW-1:0]        replay_count,
  output logic                 walk_err
);

  replay_state_t state, nstate;

  logic [BW-1:0] blk;
  logic [CW-1:0] cnt;
  logic          err;
  logic          hit;
  logic          rep_bad;

  assign hit = fill_valid & wb.wb_found_one;

  // A dropped walk or an over-long walk aborts the replay.
  assign rep_bad = (state == REPLAY) &&
                   (!wb.wb_in_walk_mode ||
                    cnt == CW'(DEPTH));

  assign replay_count = cnt;
  assign walk_err     = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (hit) nstate = WAIT;
      WAIT:    nstate = wb.wb_in_walk_mode ? REPLAY : IDLE;
      REPLAY:  if (rep_bad || !wb.wb_found_multi)
                 nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && hit) begin
        blk <= fill_address[ADDR_BITS-1:BLOCK_ID_START];
        cnt <= '0;
      end
      if (state == REPLAY && !rep_bad)
        cnt <= cnt + CW'(1);
      if ((state == WAIT && !wb.wb_in_walk_mode) || rep_bad)
        err <= 1'b1;
    end
  end

  always_comb begin
    fill_ready              = 1'b0;
    lsu_ready               = 1'b0;
    port_valid              = 1'b0;
    port_is_replay          = 1'b0;
    port_req                = '0;
    wb.wb_search_invalidate = 1'b0;
    wb.wb_search_address    = {blk, {BLOCK_ID_START{1'b0}}};
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          if (fill_valid) begin
            wb.wb_search_address    = fill_address;
            fill_ready              = 1'b1;
            wb.wb_search_invalidate = wb.wb_found_one;
          end else begin
            wb.wb_search_address = lsu_req.addr;
            lsu_ready            = 1'b1;
            port_valid           = lsu_valid;
            port_req             = lsu_req;
          end
        end
        REPLAY: begin
          port_valid     = !rep_bad;
          port_is_replay = !rep_bad;
          port_req       = wb.wb_entry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_replay_ctrl.sv
// Directed bench for the wait-buffer replay controller.
// Inputs change 1ns after posedge; outputs sampled 1ns later.
module tb_wb_replay_ctrl;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fill_valid;
  logic [31:0] fill_address;
  logic        fill_ready;
  logic        lsu_valid;
  wb_req_t     lsu_req;
  logic        lsu_ready;
  logic        port_valid;
  logic        port_is_replay;
  wb_req_t     port_req;
  logic [3:0]  replay_count;
  logic        walk_err;

  int n_run  = 0;
  int n_fail = 0;

  wb_req_t ra, rb, e0, e1, e2;

  wb_replay_ctrl_if #(.ADDR_BITS(32)) wb ();

  wb_replay_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fill_valid     (fill_valid),
    .fill_address   (fill_address),
    .fill_ready     (fill_ready),
    .lsu_valid      (lsu_valid),
    .lsu_req        (lsu_req),
    .lsu_ready      (lsu_ready),
    .wb             (wb.master),
    .port_valid     (port_valid),
    .port_is_replay (port_is_replay),
    .port_req       (port_req),
    .replay_count   (replay_count),
    .walk_err       (walk_err)
  );

  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [127:0] got,
                       logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic wb_req_t mk(logic st,
                                 logic [31:0] a,
                                 logic [31:0] d,
                                 logic [5:0] t);
    wb_req_t r;
    r.is_store = st;
    r.addr     = a;
    r.data     = d;
    r.microop  = 8'h5a;
    r.dest     = 5'd7;
    r.ticket   = t;
    return r;
  endfunction

  initial begin
    ra = mk(1'b0, 32'h0000_0100, 32'hdead_beef, 6'd1);
    rb = mk(1'b1, 32'h0000_0200, 32'hcafe_f00d, 6'd2);
    e0 = mk(1'b1, 32'h0000_2044, 32'h1111_1111, 6'd10);
    e1 = mk(1'b0, 32'h0000_2048, 32'h2222_2222, 6'd11);
    e2 = mk(1'b1, 32'h0000_205c, 32'h3333_3333, 6'd12);

    fill_valid   = 1'b1;
    fill_address = 32'h0000_1000;
    lsu_valid    = 1'b1;
    lsu_req      = ra;
    wb.wb_found_one         = 1'b1;
    wb.wb_found_multi       = 1'b0;
    wb.wb_in_walk_mode      = 1'b0;
    wb.wb_entry             = e0;

    // reset state: outputs gated low
    #12;
    check("rst_fill_ready", 128'(fill_ready), 128'(0));
    check("rst_lsu_ready", 128'(lsu_ready), 128'(0));
    check("rst_inval",
          128'(wb.wb_search_invalidate), 128'(0));
    check("rst_port_valid", 128'(port_valid), 128'(0));
    check("rst_port_req", 128'(port_req), 128'(0));
    check("rst_count", 128'(replay_count), 128'(0));
    check("rst_err", 128'(walk_err), 128'(0));
    tick();
    rst_n      = 1'b1;
    fill_valid = 1'b0;
    lsu_valid  = 1'b0;
    wb.wb_found_one = 1'b0;
    tick();

    // fill miss in the wait buffer
    fill_valid   = 1'b1;
    fill_address = 32'h0000_1000;
    lsu_valid    = 1'b1;
    #1;
    check("miss_fill_ready", 128'(fill_ready), 128'(1));
    check("miss_inval",
          128'(wb.wb_search_invalidate), 128'(0));
    check("miss_lsu_ready", 128'(lsu_ready), 128'(0));
    check("miss_srch",
          128'(wb.wb_search_address), 128'(32'h1000));
    tick();
    fill_valid = 1'b0;
    #1;
    check("lsu_ready", 128'(lsu_ready), 128'(1));
    check("lsu_pv", 128'(port_valid), 128'(1));
    check("lsu_replay", 128'(port_is_replay), 128'(0));
    check("lsu_req", 128'(port_req), 128'(ra));
    check("lsu_srch",
          128'(wb.wb_search_address), 128'(32'h100));
    tick();

    // 3-entry walk with LSU held valid
    lsu_req      = rb;
    fill_valid   = 1'b1;
    fill_address = 32'h0000_205f;
    wb.wb_found_one   = 1'b1;
    wb.wb_found_multi = 1'b1;
    #1;
    check("hit_fill_ready", 128'(fill_ready), 128'(1));
    check("hit_inval",
          128'(wb.wb_search_invalidate), 128'(1));
    check("hit_lsu_ready", 128'(lsu_ready), 128'(0));
    check("hit_pv", 128'(port_valid), 128'(0));
    tick();
    fill_valid         = 1'b0;
    wb.wb_in_walk_mode = 1'b1;
    #1;
    check("wait_srch",
          128'(wb.wb_search_address), 128'(32'h2040));
    check("wait_inval",
          128'(wb.wb_search_invalidate), 128'(0));
    check("wait_lsu_ready", 128'(lsu_ready), 128'(0));
    check("wait_pv", 128'(port_valid), 128'(0));
    check("wait_fill_ready", 128'(fill_ready), 128'(0));
    tick();
    for (int i = 0; i < 3; i++) begin
      wb.wb_entry       = (i == 0) ? e0 :
                          (i == 1) ? e1 : e2;
      wb.wb_found_multi = (i < 2);
      #1;
      check("rep_pv", 128'(port_valid), 128'(1));
      check("rep_replay", 128'(port_is_replay), 128'(1));
      check("rep_req", 128'(port_req),
            128'((i == 0) ? e0 : (i == 1) ? e1 : e2));
      check("rep_lsu_ready", 128'(lsu_ready), 128'(0));
      check("rep_count", 128'(replay_count), 128'(i));
      check("rep_srch",
            128'(wb.wb_search_address), 128'(32'h2040));
      tick();
    end
    wb.wb_in_walk_mode = 1'b0;
    wb.wb_found_one    = 1'b0;
    #1;
    check("post_count", 128'(replay_count), 128'(3));
    check("post_lsu_ready", 128'(lsu_ready), 128'(1));
    check("post_req", 128'(port_req), 128'(rb));
    check("post_replay", 128'(port_is_replay), 128'(0));
    check("post_err", 128'(walk_err), 128'(0));
    tick();
    lsu_valid = 1'b0;

    // second fill arrives mid-replay
    fill_valid   = 1'b1;
    fill_address = 32'h0000_3000;
    wb.wb_found_one   = 1'b1;
    wb.wb_found_multi = 1'b1;
    tick();
    fill_valid         = 1'b0;
    wb.wb_in_walk_mode = 1'b1;
    tick();
    wb.wb_entry  = e1;
    fill_valid   = 1'b1;
    fill_address = 32'h0000_4000;
    #1;
    check("f2_ready_r1", 128'(fill_ready), 128'(0));
    check("f2_srch",
          128'(wb.wb_search_address), 128'(32'h3000));
    tick();
    wb.wb_found_multi = 1'b0;
    #1;
    check("f2_ready_r2", 128'(fill_ready), 128'(0));
    check("f2_pv_r2", 128'(port_valid), 128'(1));
    tick();
    wb.wb_in_walk_mode = 1'b0;
    wb.wb_found_one    = 1'b0;
    #1;
    check("f2_ready_idle", 128'(fill_ready), 128'(1));
    check("f2_srch_idle",
          128'(wb.wb_search_address), 128'(32'h4000));
    check("f2_count", 128'(replay_count), 128'(2));
    tick();
    fill_valid = 1'b0;

    // over-long walk saturates and flags an error
    fill_valid   = 1'b1;
    fill_address = 32'h0000_6000;
    wb.wb_found_one   = 1'b1;
    wb.wb_found_multi = 1'b1;
    tick();
    fill_valid         = 1'b0;
    wb.wb_in_walk_mode = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    #1;
    check("sat_count", 128'(replay_count), 128'(8));
    check("sat_pv", 128'(port_valid), 128'(0));
    tick();
    wb.wb_in_walk_mode = 1'b0;
    #1;
    check("sat_err", 128'(walk_err), 128'(1));
    check("sat_idle", 128'(lsu_ready), 128'(1));
    check("sat_count_hold", 128'(replay_count), 128'(8));
    tick();

    // reset asserted in the middle of a replay
    fill_valid   = 1'b1;
    fill_address = 32'h0000_7000;
    tick();
    fill_valid         = 1'b0;
    wb.wb_in_walk_mode = 1'b1;
    tick();
    #1;
    check("mid_pv_pre", 128'(port_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_pv", 128'(port_valid), 128'(0));
    check("mid_rst_replay", 128'(port_is_replay), 128'(0));
    check("mid_rst_err", 128'(walk_err), 128'(0));
    check("mid_rst_count", 128'(replay_count), 128'(0));
    tick();
    rst_n = 1'b1;
    wb.wb_found_one = 1'b0;
    #1;
    check("mid_post_pv", 128'(port_valid), 128'(0));
    check("mid_post_idle", 128'(lsu_ready), 128'(1));
    tick();
    wb.wb_in_walk_mode = 1'b0;

    // walk never starts after the hit
    fill_valid   = 1'b1;
    fill_address = 32'h0000_5000;
    wb.wb_found_one = 1'b1;
    tick();
    fill_valid = 1'b0;
    #1;
    check("nw_pv_wait", 128'(port_valid), 128'(0));
    check("nw_err_pre", 128'(walk_err), 128'(0));
    tick();
    wb.wb_found_one = 1'b0;
    #1;
    check("nw_err", 128'(walk_err), 128'(1));
    check("nw_idle", 128'(lsu_ready), 128'(1));
    check("nw_pv", 128'(port_valid), 128'(0));
    tick();
    fill_valid   = 1'b1;
    fill_address = 32'h0000_8000;
    tick();
    fill_valid = 1'b0;
    #1;
    check("nw_sticky", 128'(walk_err), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
